// File: rtl/crossy_robbers_usb_pkg.sv
// Shared definitions for the USB PIO slaves: register addresses, status bit
// positions and the pulse-timer state encoding.
package crossy_robbers_usb_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_PULSE  = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    localparam int unsigned BUSY_BIT = 0;
    localparam int unsigned DONE_BIT = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } timer_state_e;

endpackage

// File: rtl/crossy_robbers_usb_pulse_timer.sv
// Exact-length pulse timer: load starts or restarts an N-cycle pulse, abort
// ends it early; done_pulse_c_o flags only a pulse that ran to completion.
module crossy_robbers_usb_pulse_timer
    import crossy_robbers_usb_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] len_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             done_pulse_c_o
);

    timer_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Leaving at cnt==1 gives exactly N busy cycles and keeps the count from wrapping.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        done_pulse_c_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_i) begin
                    state_d = PULSE;
                    cnt_d   = len_i;
                end
            end
            PULSE: begin
                if (abort_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (load_i) begin
                    cnt_d = len_i;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d        = IDLE;
                    cnt_d          = '0;
                    done_pulse_c_o = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy_o = (state_q == PULSE);
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/crossy_robbers_soc_usb_rst_ctl.sv
// Avalon-MM output port driving the MAX3421E reset pin: a static level
// register plus a hardware-timed pulse with busy/done status for polling.
module crossy_robbers_soc_usb_rst_ctl
    import crossy_robbers_usb_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter logic        RESET_VALUE = 1'b0,
    parameter logic        PULSE_LEVEL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        out_port
);

    logic             wr_en;
    logic             pulse_wr;
    logic [CNT_W-1:0] pulse_len;
    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic             done_pulse_c;

    logic        data_q, data_d;
    logic        done_q, done_d;
    logic        out_q, out_d;
    logic [31:0] rdata_q, rdata_d;

    logic unused_wdata;
    assign unused_wdata = ^writedata[31:CNT_W];

    assign wr_en     = chipselect & ~write_n;
    assign pulse_wr  = wr_en & (address == ADDR_PULSE);
    assign pulse_len = writedata[CNT_W-1:0];

    crossy_robbers_usb_pulse_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk            (clk),
        .reset          (reset),
        .load_i         (pulse_wr & (pulse_len != '0)),
        .abort_i        (pulse_wr & (pulse_len == '0)),
        .len_i          (pulse_len),
        .busy_o         (busy),
        .cnt_o          (cnt),
        .done_pulse_c_o (done_pulse_c)
    );

    // Register writes; a completion in the same cycle as a W1C keeps done set.
    always_comb begin
        data_d = data_q;
        done_d = done_q;
        if (wr_en && (address == ADDR_DATA)) begin
            data_d = writedata[0];
        end
        if (wr_en && (address == ADDR_STATUS) && writedata[DONE_BIT]) begin
            done_d = 1'b0;
        end
        if (done_pulse_c) begin
            done_d = 1'b1;
        end
        out_d = busy ? PULSE_LEVEL : data_q;
    end

    // Read mux is sampled every edge regardless of chipselect.
    always_comb begin
        rdata_d = '0;
        case (address)
            ADDR_DATA: begin
                rdata_d[0] = data_q;
            end
            ADDR_PULSE: begin
                rdata_d[CNT_W-1:0] = cnt;
                rdata_d[31]        = busy;
            end
            ADDR_STATUS: begin
                rdata_d[DONE_BIT] = done_q;
                rdata_d[BUSY_BIT] = busy;
            end
            default: begin
                rdata_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= RESET_VALUE;
            done_q  <= 1'b0;
            out_q   <= RESET_VALUE;
            rdata_q <= '0;
        end else begin
            data_q  <= data_d;
            done_q  <= done_d;
            out_q   <= out_d;
            rdata_q <= rdata_d;
        end
    end

    assign readdata = rdata_q;
    assign out_port = out_q;

endmodule

// File: tb/tb_crossy_robbers_soc_usb_rst_ctl.sv
// Self-checking bench for the USB reset-line controller: directed scenarios
// plus random bus traffic against a timestamp-based pulse model.
module tb_crossy_robbers_soc_usb_rst_ctl;

    localparam int unsigned CNT_W = 16;
    localparam logic        RV    = 1'b0;
    localparam logic        PL    = 1'b1;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        out_port;

    crossy_robbers_soc_usb_rst_ctl #(
        .CNT_W       (CNT_W),
        .RESET_VALUE (RV),
        .PULSE_LEVEL (PL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: the pulse is "active" for every edge index t with t < pend.
    longint      t       = 0;
    longint      pend    = 0;
    bit          natural = 1'b0;
    bit          m_data  = RV;
    bit          m_done  = 1'b0;
    logic        exp_out;
    logic [31:0] exp_rd;

    int hi_total    = 0;
    int done_rises  = 0;
    bit last_done   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit          b;
        logic [31:0] c;
        bit          we;
        longint      n;
        bit          set_done;
        b = (t < pend);
        c = b ? 32'(pend - t) : 32'd0;
        if (reset) begin
            exp_out = RV;
            exp_rd  = '0;
        end else begin
            exp_out = b ? PL : m_data;
            case (address)
                2'd0:    exp_rd = {31'd0, m_data};
                2'd1:    exp_rd = {b, 15'd0, c[15:0]};
                2'd2:    exp_rd = {30'd0, m_done, b};
                default: exp_rd = '0;
            endcase
        end
        t  = t + 1;
        we = chipselect && !write_n;
        if (reset) begin
            m_data  = RV;
            m_done  = 1'b0;
            pend    = t;
            natural = 1'b0;
        end else begin
            set_done = natural && (t == pend) && !(we && address == 2'd1);
            if (we && address == 2'd0) m_data = writedata[0];
            if (we && address == 2'd1) begin
                n = longint'(writedata[15:0]);
                if (n != 0) begin
                    pend    = t + n;
                    natural = 1'b1;
                end else if (b) begin
                    pend    = t;
                    natural = 1'b0;
                end
            end
            if (we && address == 2'd2 && writedata[1]) m_done = 1'b0;
            if (set_done) m_done = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("out_port", 32'(out_port), 32'(exp_out));
        chk("readdata", readdata, exp_rd);
        if (out_port === PL) hi_total++;
        if (address == 2'd2) begin
            if (readdata[1] && !last_done) done_rises++;
            last_done = readdata[1];
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a);
        address = a;
        tick();
    endtask

    task automatic wait_low(input int limit);
        int n;
        n = 0;
        while (out_port === PL && n < limit) begin
            tick();
            n++;
        end
        chk("wait_low_timeout", 32'(n < limit), 32'd1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = '0;
        repeat (2) tick();
        chk("rst_out_port", 32'(out_port), 32'(RV));
        reset = 1'b0;

        // Reset state at every address
        for (int a = 0; a < 4; a++) begin
            rd(2'(a));
            chk("rst_readdata", readdata, 32'd0);
        end

        // Static level and chipselect gating
        wr(2'd0, 32'd1);
        rd(2'd0);
        chk("data_out", 32'(out_port), 32'd1);
        rd(2'd0);
        chk("data_rd", readdata, 32'd1);
        address = 2'd0; chipselect = 1'b0; write_n = 1'b0; writedata = 32'd0;
        tick();
        write_n = 1'b1;
        rd(2'd0);
        chk("cs0_out", 32'(out_port), 32'd1);
        chk("cs0_rd", readdata, 32'd1);
        wr(2'd0, 32'd0);
        rd(2'd2);

        // Five-cycle pulse with status polling and W1C
        hi_total = 0;
        wr(2'd1, 32'd5);
        address = 2'd2;
        tick();
        chk("p5_status_busy", readdata, 32'd1);
        wait_low(100);
        chk("p5_high", 32'(hi_total), 32'd5);
        chk("p5_status_done", readdata, 32'd2);
        wr(2'd2, 32'd2);
        rd(2'd2);
        chk("w1c_status", readdata, 32'd0);

        // Retrigger: 4 high cycles before the reload plus 3 after
        hi_total = 0; done_rises = 0; last_done = 1'b0;
        wr(2'd1, 32'd10);
        address = 2'd2;
        repeat (3) tick();
        wr(2'd1, 32'd3);
        address = 2'd2;
        tick();
        wait_low(100);
        repeat (3) tick();
        chk("retrig_high", 32'(hi_total), 32'd7);
        chk("retrig_done_once", 32'(done_rises), 32'd1);
        wr(2'd2, 32'd2);
        rd(2'd2);

        // Abort on the third edge after the start
        hi_total = 0;
        wr(2'd1, 32'd10);
        address = 2'd2;
        repeat (2) tick();
        wr(2'd1, 32'd0);
        rd(2'd2);
        chk("abort_out", 32'(out_port), 32'd0);
        chk("abort_high", 32'(hi_total), 32'd3);
        repeat (3) tick();
        chk("abort_status", readdata, 32'd0);

        // DATA write while pulsing reaches the pin only after the pulse
        hi_total = 0;
        wr(2'd1, 32'd6);
        address = 2'd2;
        tick();
        wr(2'd0, 32'd1);
        address = 2'd2;
        repeat (4) tick();
        chk("dpulse_high", 32'(hi_total), 32'd6);
        tick();
        chk("dpulse_out_after", 32'(out_port), 32'd1);
        chk("dpulse_status", readdata, 32'd2);
        wr(2'd2, 32'd2);
        wr(2'd0, 32'd0);

        // Reset in the middle of a pulse
        wr(2'd1, 32'd8);
        address = 2'd2;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("midrst_out", 32'(out_port), 32'(RV));
        reset = 1'b0;
        repeat (3) tick();
        chk("midrst_status", readdata, 32'd0);
        chk("midrst_out_after", 32'(out_port), 32'(RV));

        // Maximum-length pulse
        hi_total = 0;
        wr(2'd1, 32'h0000_FFFF);
        address = 2'd1;
        tick();
        chk("max_cnt_rd", readdata, 32'h8000_FFFF);
        wait_low(70000);
        chk("max_high", 32'(hi_total), 32'd65535);
        wr(2'd2, 32'd2);

        // Random bus traffic against the model
        for (int i = 0; i < 1500; i++) begin
            reset      = ($urandom_range(0, 299) == 0);
            chipselect = 1'($urandom_range(0, 1));
            write_n    = 1'($urandom_range(0, 1));
            address    = 2'($urandom_range(0, 3));
            writedata  = $urandom;
            if (address == 2'd1) writedata[15:0] = 16'($urandom_range(0, 12));
            tick();
        end
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        repeat (20) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
